// File: rtl/uart_tx_sched_if.sv
// Requester/transmitter-side signal bundle for uart_tx_sched.
// The scheduler takes the slave view; requesters and the transmitter pins take the master view.
interface uart_tx_sched_if #(
    parameter int NREQ = 4
);

    logic [NREQ-1:0]   Req;
    logic [NREQ*8-1:0] Data;
    logic [NREQ-1:0]   Ack;
    logic [NREQ-1:0]   Sent;
    logic              Err;
    logic              Busy;
    logic              TxEn;
    logic [7:0]        TxData;
    logic              TxDone;

    modport slave (
        input  Req,
        input  Data,
        input  TxDone,
        output Ack,
        output Sent,
        output Err,
        output Busy,
        output TxEn,
        output TxData
    );

    modport master (
        output Req,
        output Data,
        output TxDone,
        input  Ack,
        input  Sent,
        input  Err,
        input  Busy,
        input  TxEn,
        input  TxData
    );

endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART_tx transmitter among NREQ byte requesters.
// Define UART_TX_SCHED_TIMEOUT_EN to build the per-frame watchdog (TIMEOUT cycles, 16-bit counter).
module uart_tx_sched #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 20000
) (
    input  logic           Clk,
    input  logic           Rst_n,
    uart_tx_sched_if.slave bus
);

    localparam int DATA_W = 8;
    localparam int IDX_W  = $clog2(NREQ);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_DONE,
        S_WAIT_CLR
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic              launch_q, launch_d;
    logic              done_q, done_d;
    logic              txen_q, txen_d;
    logic [DATA_W-1:0] txdata_q, txdata_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic [NREQ-1:0]   sent_q, sent_d;
    logic              err_q, err_d;
    logic              grant_vld;
    logic [IDX_W-1:0]  grant_idx;
    logic              timeout;

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_err
        $error("uart_tx_sched: NREQ or TIMEOUT out of range");
    end

    // Rotating priority: the requester just after the last grant is looked at first.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = last_q;
        for (int k = 1; k <= NREQ; k++) begin
            if (!grant_vld && bus.Req[(int'(last_q) + k) % NREQ]) begin
                grant_vld = 1'b1;
                grant_idx = IDX_W'((int'(last_q) + k) % NREQ);
            end
        end
    end

`ifdef UART_TX_SCHED_TIMEOUT_EN
    logic [15:0] wd_q, wd_d;

    // Held at zero outside the wait states, so it starts from zero on entry to WAIT_DONE.
    always_comb begin
        wd_d = '0;
        if (state_q == S_WAIT_DONE || state_q == S_WAIT_CLR) begin
            wd_d = wd_q + 16'd1;
        end
    end

    assign timeout = (state_q == S_WAIT_DONE || state_q == S_WAIT_CLR) &&
                     (wd_q == 16'(TIMEOUT - 1));

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        launch_d = launch_q;
        done_d   = bus.TxDone;
        txen_d   = txen_q;
        txdata_d = txdata_q;
        ack_d    = '0;
        sent_d   = '0;
        err_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                txen_d = 1'b0;
                if (grant_vld) begin
                    txdata_d         = bus.Data[DATA_W*int'(grant_idx) +: DATA_W];
                    ack_d[grant_idx] = 1'b1;
                    txen_d           = 1'b1;
                    last_d           = grant_idx;
                    launch_d         = 1'b0;
                    state_d          = S_LAUNCH;
                end
            end
            // TxEn is held for two cycles so the transmitter's 2-flop synchroniser sees one clean edge.
            S_LAUNCH: begin
                if (launch_q) begin
                    txen_d  = 1'b0;
                    state_d = S_WAIT_DONE;
                end else begin
                    launch_d = 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (bus.TxDone && !done_q) begin
                    sent_d[last_q] = 1'b1;
                    state_d        = S_WAIT_CLR;
                end
            end
            S_WAIT_CLR: begin
                if (!bus.TxDone) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (timeout) begin
            err_d   = 1'b1;
            sent_d  = '0;
            txen_d  = 1'b0;
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= S_IDLE;
            last_q   <= IDX_W'(NREQ - 1);
            launch_q <= 1'b0;
            done_q   <= 1'b0;
            txen_q   <= 1'b0;
            txdata_q <= '0;
            ack_q    <= '0;
            sent_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            launch_q <= launch_d;
            done_q   <= done_d;
            txen_q   <= txen_d;
            txdata_q <= txdata_d;
            ack_q    <= ack_d;
            sent_q   <= sent_d;
            err_q    <= err_d;
        end
    end

    assign bus.Ack    = ack_q;
    assign bus.Sent   = sent_q;
    assign bus.Err    = err_q;
    assign bus.Busy   = (state_q != S_IDLE);
    assign bus.TxEn   = txen_q;
    assign bus.TxData = txdata_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: frame-timeline reference model compared every cycle plus directed scenarios.
// The watchdog scenario runs only when UART_TX_SCHED_TIMEOUT_EN is defined.
module tb_uart_tx_sched;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 100;
`ifdef UART_TX_SCHED_TIMEOUT_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    logic Clk   = 1'b0;
    logic Rst_n = 1'b0;
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_pass = 0;

    uart_tx_sched_if #(.NREQ(NREQ)) bus ();

    uart_tx_sched #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    endtask

    // Reference model: a frame is a timeline counted from the Ack cycle (age 0).
    // TxEn is high at ages 0 and 1; waiting for TxDone starts at age 2.
    bit              m_active, m_done_seen, m_prev_done;
    int              m_age, m_owner, m_last;
    logic [NREQ-1:0] e_ack, e_sent;
    logic            e_err, e_busy, e_txen;
    logic [7:0]      e_txdata;

    int grants[$];
    int sent_cnt[NREQ];
    int txen_cycles;
    int err_cnt;

    function automatic void model_reset();
        m_active = 0; m_done_seen = 0; m_prev_done = 0;
        m_age = 0; m_owner = 0; m_last = NREQ - 1;
        e_ack = '0; e_sent = '0; e_err = 0; e_busy = 0; e_txen = 0; e_txdata = '0;
    endfunction

    function automatic void model_step();
        bit found = 0;
        e_ack = '0; e_sent = '0; e_err = 1'b0;
        if (!m_active) begin
            for (int s = 1; s <= NREQ; s++) begin
                int r = (m_last + s) % NREQ;
                if (!found && bus.Req[r]) begin
                    found   = 1;
                    m_owner = r;
                end
            end
            if (found) begin
                m_active       = 1;
                m_age          = 0;
                m_done_seen    = 0;
                m_last         = m_owner;
                e_ack[m_owner] = 1'b1;
                e_txdata       = bus.Data[8*m_owner +: 8];
            end
        end else begin
            if (WD_EN && m_age >= 2 && (m_age - 1) == TIMEOUT) begin
                e_err    = 1'b1;
                m_active = 0;
            end else if (m_age >= 2 && !m_done_seen && bus.TxDone && !m_prev_done) begin
                e_sent[m_owner] = 1'b1;
                m_done_seen     = 1;
            end else if (m_done_seen && !bus.TxDone) begin
                m_active = 0;
            end
            m_age++;
        end
        m_prev_done = bus.TxDone;
        e_busy = m_active;
        e_txen = m_active && (m_age < 2);
    endfunction

    always @(negedge Clk) begin
        if (!Rst_n) model_reset();
        check("Ack",    bus.Ack,    e_ack);
        check("Sent",   bus.Sent,   e_sent);
        check("Err",    bus.Err,    e_err);
        check("Busy",   bus.Busy,   e_busy);
        check("TxEn",   bus.TxEn,   e_txen);
        check("TxData", bus.TxData, e_txdata);
        for (int i = 0; i < NREQ; i++) begin
            if (bus.Ack[i])  grants.push_back(i);
            if (bus.Sent[i]) sent_cnt[i]++;
        end
        if (bus.TxEn) txen_cycles++;
        if (bus.Err)  err_cnt++;
        if (Rst_n) model_step();
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic clear_obs();
        grants.delete();
        for (int i = 0; i < NREQ; i++) sent_cnt[i] = 0;
        txen_cycles = 0;
        err_cnt     = 0;
    endtask

    // kind: 0 TxEn high, 1 TxEn low, 2 any Ack, 3 Err high
    task automatic wait_for(input string what, input int kind, output int at);
        bit hit = 0;
        at = -1;
        for (int n = 0; n < 1000 && !hit; n++) begin
            @(negedge Clk);
            case (kind)
                0:       hit = (bus.TxEn === 1'b1);
                1:       hit = (bus.TxEn === 1'b0);
                2:       hit = (bus.Ack !== '0);
                default: hit = (bus.Err === 1'b1);
            endcase
            if (hit) at = cyc;
        end
        check(what, 32'(hit), 32'd1);
    endtask

    task automatic tx_frame(input int rise_delay, input int hold,
                            input logic [NREQ-1:0] req_after, output int fall_at);
        int t;
        wait_for("frame TxEn high", 0, t);
        wait_for("frame TxEn low", 1, t);
        step(rise_delay);
        bus.TxDone = 1'b1;
        bus.Req    = req_after;
        step(hold);
        bus.TxDone = 1'b0;
        fall_at    = cyc;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global time limit reached, passed %0d of %0d", n_pass, n_chk);
        $fatal(1, "time limit");
    end

    initial begin
        int       req_at, ack_at, fall_at, rise_at, err_at, t;
        int       exp_order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        bit       all_two;

        bus.Req    = '0;
        bus.Data   = 32'h3322_115A;
        bus.TxDone = 1'b0;
        step(3);
        check("reset TxEn",   bus.TxEn,   0);
        check("reset TxData", bus.TxData, 0);
        check("reset Busy",   bus.Busy,   0);
        check("reset Ack",    bus.Ack,    0);
        check("reset Sent",   bus.Sent,   0);
        check("reset Err",    bus.Err,    0);
        Rst_n = 1'b1;
        step(2);

        // Single requester, 160-cycle frame
        clear_obs();
        bus.Req = 4'b0001;
        req_at  = cyc;
        wait_for("single ack", 2, ack_at);
        check("single ack latency", ack_at - req_at, 1);
        check("single ack vector",  bus.Ack, 4'b0001);
        check("single TxData",      bus.TxData, 8'h5A);
        step();
        bus.Req = '0;
        tx_frame(160, 4, '0, fall_at);
        step(2);
        check("single TxEn cycles", txen_cycles, 2);
        check("single Sent count",  sent_cnt[0], 1);
        check("single Busy after",  bus.Busy, 0);

        // Contention from reset: four requesters held for eight frames
        Rst_n = 1'b0;
        step(2);
        Rst_n = 1'b1;
        clear_obs();
        bus.Data = 32'h4433_2211;
        bus.Req  = 4'b1111;
        for (int f = 0; f < 8; f++) tx_frame(3, 2, (f == 7) ? 4'b0000 : 4'b1111, fall_at);
        step(3);
        check("contention grants", grants.size(), 8);
        if (grants.size() == 8)
            for (int i = 0; i < 8; i++) check("contention order", grants[i], exp_order[i]);
        all_two = 1;
        for (int i = 0; i < NREQ; i++) if (sent_cnt[i] != 2) all_two = 0;
        check("contention Sent twice each", 32'(all_two), 1);
        check("contention TxEn cycles", txen_cycles, 16);

        // Back-to-back on requester 2 with TxDone held five cycles
        clear_obs();
        bus.Req = 4'b0100;
        tx_frame(4, 5, 4'b0100, fall_at);
        wait_for("b2b relaunch", 0, rise_at);
        check("b2b relaunch gap", rise_at - fall_at, 2);
        tx_frame(4, 1, '0, fall_at);
        step(3);
        check("b2b ack count", grants.size(), 2);
        check("b2b Sent count", sent_cnt[2], 2);

        // Stale TxDone already high at launch
        clear_obs();
        bus.Req    = 4'b0001;
        bus.TxDone = 1'b1;
        wait_for("stale ack", 2, t);
        check("stale ack vector", bus.Ack, 4'b0001);
        step();
        bus.Req = '0;
        wait_for("stale TxEn low", 1, t);
        step(3);
        bus.TxDone = 1'b0;
        step(3);
        check("stale no Sent", sent_cnt[0], 0);
        check("stale still Busy", bus.Busy, 1);
        bus.TxDone = 1'b1;
        step(2);
        bus.TxDone = 1'b0;
        step(3);
        check("stale fresh Sent", sent_cnt[0], 1);
        check("stale idle after", bus.Busy, 0);

        // Reset during WAIT_DONE
        clear_obs();
        bus.Req = 4'b0010;
        wait_for("midrst ack", 2, t);
        check("midrst ack vector", bus.Ack, 4'b0010);
        step();
        bus.Req = '0;
        wait_for("midrst TxEn low", 1, t);
        step(2);
        Rst_n = 1'b0;
        #1;
        check("midrst TxEn",   bus.TxEn,   0);
        check("midrst TxData", bus.TxData, 0);
        check("midrst Busy",   bus.Busy,   0);
        bus.Req = 4'b0011;
        step(2);
        Rst_n = 1'b1;
        wait_for("postrst ack", 2, t);
        check("postrst ack vector", bus.Ack, 4'b0001);
        step();
        bus.Req = '0;
        tx_frame(3, 1, '0, fall_at);
        step(3);
        check("midrst no Sent", sent_cnt[1], 0);
        check("postrst Sent",   sent_cnt[0], 1);
        check("midrst no Err",  err_cnt, 0);

`ifdef UART_TX_SCHED_TIMEOUT_EN
        // Watchdog: TxDone never rises for requester 2, requester 0 pending
        clear_obs();
        bus.Req = 4'b0101;
        wait_for("wd ack", 2, t);
        check("wd ack vector", bus.Ack, 4'b0100);
        step();
        bus.Req = 4'b0001;
        wait_for("wd TxEn low", 1, fall_at);
        wait_for("wd Err", 3, err_at);
        check("wd Err delay", err_at - fall_at, 100);
        check("wd no Sent", sent_cnt[2], 0);
        wait_for("wd next ack", 2, ack_at);
        check("wd next ack vector", bus.Ack, 4'b0001);
        check("wd next ack delay", ack_at - err_at, 1);
        step();
        bus.Req = '0;
        tx_frame(3, 1, '0, fall_at);
        step(3);
        check("wd Err count", err_cnt, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin scheduler that shares one `UART_tx` transmitter among `NREQ` byte requesters. It sits between requester blocks and the transmitter's `TxEn`/`TxData`/`TxDone` pins. For each frame it:
- selects a requester and latches its byte;
- generates the clean `TxEn` rising edge the transmitter requires;
- waits for the frame to complete and for `TxDone` to clear before launching the next frame.

## Interface
- `NREQ`, 4, number of requesters (2..8).
- `TIMEOUT`, 20000, Clk cycles allowed per frame before abort (watchdog builds only); counter is 16 bits wide.
- `Clk`  in  1  system clock; same clock as the transmitter's `Clk`.
- `Rst_n`  in  1  asynchronous, active-low reset.
- `Req`  in  NREQ  level request, one bit per requester; `Data` must stay stable while the bit is high.
- `Data`  in  NREQ*8  flattened bytes; requester i uses `Data[8*i+7:8*i]`.
- `Ack`  out  NREQ  one-cycle pulse when the requester's byte is latched.
- `Sent`  out  NREQ  one-cycle pulse when that requester's frame completes.
- `Err`  out  1  one-cycle pulse when the watchdog aborts a frame.
- `Busy`  out  1  high in every state except IDLE.
- `TxEn`  out  1  drives transmitter `TxEn`.
- `TxData`  out  8  drives transmitter `TxData`; held stable from latch until return to IDLE.
- `TxDone`  in  1  transmitter `TxDone` (level).

## Operation
- States:
  - IDLE
  - LAUNCH: 2 cycles.
  - WAIT_DONE
  - WAIT_CLR
- Grant pointer `last` holds the index of the most recent grant. Arbitration scans `last+1`, `last+2`, … modulo `NREQ`; the first requester with `Req` high wins.
- IDLE, any `Req` high:
  - grant g;
  - `TxData`<=`Data[g]`, `Ack[g]`<=1, `TxEn`<=1, `last`<=g;
  - go to LAUNCH.
- IDLE, no `Req` high: stay; `TxEn`=0.
- LAUNCH: `TxEn` stays high for 2 cycles, then `TxEn`<=0 and go to WAIT_DONE. The transmitter's 2-flop edge detector sees exactly one rising edge.
- WAIT_DONE: `TxDone` is registered once as `done_q`. A rising edge (`TxDone`=1, `done_q`=0) pulses `Sent[g]` and moves to WAIT_CLR. `TxDone` already high on entry does not count; only a 0→1 transition counts.
- WAIT_CLR: when `TxDone`=0, go to IDLE. This state is mandatory: a `TxEn` edge while `TxDone` is still high would be swallowed by the transmitter.
- Requester protocol:
  - In the cycle after `Ack`, the requester either drops `Req` or presents its next byte.
  - `Req` still high in IDLE is treated as a new byte.
  - `Req` dropped before grant withdraws the request; no `Ack` is issued.
- Only one grant is outstanding at a time. `Ack` and `Sent` are one-hot or zero.

## Timing
- Reset values:
  - `TxEn`=0, `TxData`=0, `Ack`=0, `Sent`=0, `Err`=0, `Busy`=0;
  - state IDLE, `done_q`=0, `last`=`NREQ-1` (requester 0 wins first).
- `Req` sampled at edge t gives `Ack`, `TxData` and `TxEn` high in cycle t+1; `TxEn` falls at t+3.
- `Sent` pulses in the cycle after the `TxDone` rise is sampled.
- Minimum gap between two launches: one IDLE cycle after `TxDone` is sampled low.
- `Busy` rises together with `Ack` and falls on entry to IDLE.
- Reset mid-frame: all outputs return to reset values immediately. No `Sent` or `Err` pulse is produced. `Rst_n` is shared with the transmitter.
- Simultaneous requests: resolved purely by rotating priority. Each active requester is served within `NREQ` frames.

## Configuration
- `UART_TX_SCHED_TIMEOUT_EN` defined:
  - a 16-bit counter clears on entering WAIT_DONE and counts every cycle in WAIT_DONE and WAIT_CLR;
  - reaching `TIMEOUT` pulses `Err`, suppresses `Sent`, forces `TxEn`=0 and returns to IDLE.
- Macro undefined: no counter; the scheduler waits indefinitely and `Err` is tied to 0.

## Test plan
- Single requester: `Req[0]`=1, `Data[7:0]`=0x5A, transmitter model raises `TxDone` after 160 ticks → `Ack[0]` pulse, `TxData`=0x5A, `TxEn` high for exactly 2 cycles, `Sent[0]` one pulse, `Busy` low after `TxDone` falls.
- Contention: `Req`=4'b1111 held for 8 frames from reset → grant order 0,1,2,3,0,1,2,3; each `Sent` bit pulses exactly twice.
- Back-to-back: `Req[2]` held high, `TxDone` stays high for 5 cycles after its rise → next `TxEn` rise no earlier than 2 cycles after `TxDone` returns to 0; second `Ack[2]` occurs.
- Stale done: `TxDone` held high when a launch starts, then pulled low → no `Sent` until a fresh 0→1 transition.
- Reset mid-frame: `Rst_n` low during WAIT_DONE → `TxEn`, `TxData`, `Busy` = 0 at once; no `Sent` pulse; requester 0 wins first after release.
- Watchdog (macro defined, `TIMEOUT`=100): `TxDone` never rises → `Err` pulses at cycle 100 of WAIT_DONE, no `Sent`, state IDLE; the next pending requester is granted.
